// File: rtl/gx_link_monitor.sv
// gx_link_monitor: qualifies the GXB receive link after rx_digitalreset release
// and requests a transceiver re-reset on sync loss or excessive word errors.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   rx_digitalreset     receiver held in reset by the reset sequencer
//   rx_syncstatus[1:0]  per-byte word-aligner sync
//   rx_errdetect[1:0]   per-byte 8b/10b code error
//   rx_disperr[1:0]     per-byte disparity error
//   link_up             link qualified and usable
//   relink_req          REQ_LEN-cycle pulse requesting a re-reset
//   link_state[2:0]     FSM state for debug (IDLE=0 .. LINK_LOST=4)
//   err_total[15:0]     saturating bad-word count, live only with GX_LINK_ERRCNT_EN
//   err_clr             clears err_total, used only with GX_LINK_ERRCNT_EN
module gx_link_monitor #(
  parameter int SYNC_TIMEOUT = 50000,
  parameter int GOOD_CNT     = 64,
  parameter int ERR_MAX      = 15,
  parameter int DECAY        = 256,
  parameter int REQ_LEN      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_digitalreset,
  input  logic [1:0]  rx_syncstatus,
  input  logic [1:0]  rx_errdetect,
  input  logic [1:0]  rx_disperr,
  output logic        link_up,
  output logic        relink_req,
  output logic [2:0]  link_state,
  output logic [15:0] err_total,
  input  logic        err_clr
);
  localparam int GW = $clog2(GOOD_CNT + 1);
  localparam int DW = $clog2(DECAY + 1);
  localparam int RW = $clog2(REQ_LEN + 1);
  localparam logic [15:0]   TMO_LAST   = 16'(SYNC_TIMEOUT - 1);
  localparam logic [GW-1:0] GOOD_LAST  = GW'(GOOD_CNT - 1);
  localparam logic [7:0]    ERR_LAST   = 8'(ERR_MAX - 1);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY - 1);
  localparam logic [RW-1:0] REQ_LAST   = RW'(REQ_LEN - 1);
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_SYNC = 3'd1, CHECK = 3'd2, LINK_UP = 3'd3, LINK_LOST = 3'd4} state_t;
  state_t        state;
  logic [15:0]   tmo;
  logic [GW-1:0] good_run;
  logic [7:0]    bucket;
  logic [DW-1:0] decay;
  logic [RW-1:0] req_cnt;
  logic          synced;
  logic          good;
  assign synced     = rx_syncstatus == 2'b11;
  assign good       = synced && rx_errdetect == 2'b00 && rx_disperr == 2'b00;
  assign link_state = state;
  // Bucket never exceeds ERR_MAX because reaching it leaves LINK_UP, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      link_up    <= 1'b0;
      relink_req <= 1'b0;
      tmo        <= '0;
      good_run   <= '0;
      bucket     <= '0;
      decay      <= '0;
      req_cnt    <= '0;
    end else if (rx_digitalreset && state != LINK_LOST) begin
      state      <= IDLE;
      link_up    <= 1'b0;
      relink_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= WAIT_SYNC;
          tmo   <= '0;
        end
        WAIT_SYNC: begin
          tmo <= tmo + 1'b1;
          if (synced) begin
            state    <= CHECK;
            good_run <= '0;
          end else if (tmo == TMO_LAST) begin
            state      <= LINK_LOST;
            relink_req <= 1'b1;
            req_cnt    <= '0;
          end
        end
        CHECK: begin
          if (good) begin
            good_run <= good_run + 1'b1;
            if (good_run == GOOD_LAST) begin
              state   <= LINK_UP;
              link_up <= 1'b1;
              bucket  <= '0;
              decay   <= '0;
            end
          end else if (!synced) begin
            state <= WAIT_SYNC;
            tmo   <= '0;
          end else begin
            good_run <= '0;
          end
        end
        LINK_UP: begin
          if (!synced) begin
            state      <= LINK_LOST;
            link_up    <= 1'b0;
            relink_req <= 1'b1;
            req_cnt    <= '0;
          end else if (!good) begin
            bucket <= bucket + 1'b1;
            decay  <= '0;
            if (bucket == ERR_LAST) begin
              state      <= LINK_LOST;
              link_up    <= 1'b0;
              relink_req <= 1'b1;
              req_cnt    <= '0;
            end
          end else if (decay == DECAY_LAST) begin
            decay  <= '0;
            bucket <= bucket == 8'd0 ? 8'd0 : bucket - 1'b1;
          end else begin
            decay <= decay + 1'b1;
          end
        end
        LINK_LOST: begin
          if (req_cnt == REQ_LAST) begin
            state      <= IDLE;
            relink_req <= 1'b0;
          end else begin
            req_cnt <= req_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef GX_LINK_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr)
      err_total <= '0;
    else if ((state == CHECK || state == LINK_UP) && !good && err_total != 16'hFFFF)
      err_total <= err_total + 1'b1;
  end
`else
  logic unused_err_clr;
  assign err_total      = '0;
  assign unused_err_clr = err_clr;
`endif
endmodule
